denise_collision: RTL and testbench

DENISE_COLLISION -- requirements
Module: denise_collision

---
 rtl/denise_collision_pkg.sv | 32 +++
 rtl/denise_collision_match.sv | 51 +++++
 rtl/denise_collision.sv | 99 +++++++++
 tb/tb_denise_collision.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/denise_collision_pkg.sv
// Shared definitions for the Denise sprite/bitplane collision block.
// Holds the custom-register addresses, the layout of the collision
// hit vector (CLXDAT bits 14:0) and the decoded collision-control record.
package denise_collision_pkg;

  // Custom register byte addresses (bit 0 is never presented on the bus).
  localparam logic [8:0] CLXDAT_ADDR  = 9'h00E;
  localparam logic [8:0] CLXCON_ADDR  = 9'h098;
  localparam logic [8:0] CLXCON2_ADDR = 9'h10E;

  // Hit vector layout.
  localparam int HIT_W      = 15;
  localparam int H_ODD_EVEN = 0;   // odd planes vs even planes
  localparam int H_ODD_G0   = 1;   // odd planes vs sprite groups 0..3 -> 1..4
  localparam int H_EVEN_G0  = 5;   // even planes vs sprite groups 0..3 -> 5..8
  localparam int H_G0_G1    = 9;
  localparam int H_G0_G2    = 10;
  localparam int H_G0_G3    = 11;
  localparam int H_G1_G2    = 12;
  localparam int H_G1_G3    = 13;
  localparam int H_G2_G3    = 14;

  typedef logic [HIT_W-1:0] hit_t;

  // Decoded collision control: CLXCON plus the AGA planes 7/8 from CLXCON2.
  typedef struct packed {
    logic [3:0] ensp;  // ensp[k] enables odd sprite 2k+1 into group k
    logic [8:1] enbp;  // plane participates in its odd/even match
    logic [8:1] mvbp;  // value the plane must hold to match
  } clx_cfg_t;

endpackage

// File: rtl/denise_collision_match.sv
// Combinational collision detector for one pixel.
//   cfg_i      : decoded collision control
//   bpldata_i  : serial bitplane bits 8..1 of the current pixel
//   nsprite_i  : per-sprite non-transparent flags
//   window_i   : pixel lies inside the display window
//   hit_o      : 15-bit collision vector, all zero outside the window
module denise_collision_match
  import denise_collision_pkg::*;
(
  input  clx_cfg_t   cfg_i,
  input  logic [8:1] bpldata_i,
  input  logic [7:0] nsprite_i,
  input  logic       window_i,
  output hit_t       hit_o
);

  logic [8:1] match;
  logic       odd;
  logic       even;
  logic [3:0] grp;
  hit_t       raw;

  always_comb begin
    for (int i = 1; i <= 8; i++) begin
      match[i] = !cfg_i.enbp[i] || (bpldata_i[i] == cfg_i.mvbp[i]);
    end
    odd  = match[1] & match[3] & match[5] & match[7];
    even = match[2] & match[4] & match[6] & match[8];

    // Even sprite always counts; its odd partner only when enabled.
    for (int k = 0; k < 4; k++) begin
      grp[k] = nsprite_i[2*k] | (cfg_i.ensp[k] & nsprite_i[2*k+1]);
    end

    raw = '0;
    raw[H_ODD_EVEN] = odd & even;
    for (int k = 0; k < 4; k++) begin
      raw[H_ODD_G0 + k]  = odd  & grp[k];
      raw[H_EVEN_G0 + k] = even & grp[k];
    end
    raw[H_G0_G1] = grp[0] & grp[1];
    raw[H_G0_G2] = grp[0] & grp[2];
    raw[H_G0_G3] = grp[0] & grp[3];
    raw[H_G1_G2] = grp[1] & grp[2];
    raw[H_G1_G3] = grp[1] & grp[3];
    raw[H_G2_G3] = grp[2] & grp[3];

    hit_o = window_i ? raw : '0;
  end

endmodule

// File: rtl/denise_collision.sv
// Denise collision detection: CLXCON/CLXCON2 control registers, per-pixel
// hit evaluation, one-cycle hit pipeline and the sticky CLXDAT flags with
// clear-on-read.
//   clk, reset, clk7_en : bus clock, sync active-high reset, 7 MHz enable
//   aga                 : enables writes to CLXCON2
//   reg_address_in      : custom register address [8:1]
//   data_in             : register write data
//   bpldata, nsprite    : current pixel's bitplane bits and sprite flags
//   window              : pixel inside the display window
//   data_out            : CLXDAT read data, zero when not addressed
module denise_collision
  import denise_collision_pkg::*;
#(
  parameter logic [8:0] CLXDAT  = CLXDAT_ADDR,
  parameter logic [8:0] CLXCON  = CLXCON_ADDR,
  parameter logic [8:0] CLXCON2 = CLXCON2_ADDR
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        aga,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [8:1]  bpldata,
  input  logic [7:0]  nsprite,
  input  logic        window,
  output logic [15:0] data_out
);

  logic [15:0] clxcon_q, clxcon_d;
  logic [3:0]  clxcon2_q, clxcon2_d;  // {ENBP8, ENBP7, MVBP8, MVBP7}
  hit_t        hit_p0;
  hit_t        hit_p1_q, hit_p1_d;
  hit_t        clx_q, clx_d;
  clx_cfg_t    cfg;
  logic        sel_clxdat;
  logic        sel_clxcon;
  logic        sel_clxcon2;

  assign sel_clxdat  = (reg_address_in == CLXDAT[8:1]);
  assign sel_clxcon  = (reg_address_in == CLXCON[8:1]);
  assign sel_clxcon2 = (reg_address_in == CLXCON2[8:1]);

  always_comb begin
    cfg.ensp = clxcon_q[15:12];
    cfg.enbp = {clxcon2_q[3:2], clxcon_q[11:6]};
    cfg.mvbp = {clxcon2_q[1:0], clxcon_q[5:0]};
  end

  // Stage 0: evaluate the current pixel against the registered control,
  // so a control write only affects pixels from the following cycle.
  denise_collision_match u_match (
    .cfg_i     (cfg),
    .bpldata_i (bpldata),
    .nsprite_i (nsprite),
    .window_i  (window),
    .hit_o     (hit_p0)
  );

  always_comb begin
    clxcon_d  = clxcon_q;
    clxcon2_d = clxcon2_q;
    if (sel_clxcon) begin
      clxcon_d  = data_in;
      clxcon2_d = '0;
    end else if (sel_clxcon2 && aga) begin
      clxcon2_d = {data_in[7:6], data_in[1:0]};
    end

    hit_p1_d = hit_p0;

    // Stage 1: a read reloads the flags with only the hits in flight,
    // so nothing arriving during the read is lost.
    if (sel_clxdat) begin
      clx_d = hit_p1_q;
    end else begin
      clx_d = clx_q | hit_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        clxcon_q  <= '0;
        clxcon2_q <= '0;
        hit_p1_q  <= '0;
        clx_q     <= '0;
      end else begin
        clxcon_q  <= clxcon_d;
        clxcon2_q <= clxcon2_d;
        hit_p1_q  <= hit_p1_d;
        clx_q     <= clx_d;
      end
    end
  end

  assign data_out = sel_clxdat ? {1'b1, clx_q} : 16'h0000;

endmodule

// File: tb/tb_denise_collision.sv
module tb_denise_collision;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic        aga;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic [8:1]  bpldata;
  logic [7:0]  nsprite;
  logic        window;
  logic [15:0] data_out;

  localparam logic [8:1] A_IDLE    = 8'h00;
  localparam logic [8:1] A_CLXDAT  = 8'h07;
  localparam logic [8:1] A_CLXCON  = 8'h4C;
  localparam logic [8:1] A_CLXCON2 = 8'h87;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        sample = 1'b0;
  logic        done   = 1'b0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  always #5 clk = ~clk;

  denise_collision dut (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .aga            (aga),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .bpldata        (bpldata),
    .nsprite        (nsprite),
    .window         (window),
    .data_out       (data_out)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [8:1] addr, input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    reg_address_in = addr;
    sample = 1'b1;
    cyc(1);
    sample = 1'b0;
    reg_address_in = A_IDLE;
  endtask

  task automatic rd(input logic [15:0] e, input string nm);
    expect_out(A_CLXDAT, e, nm);
  endtask

  task automatic wr(input logic [8:1] addr, input logic [15:0] d);
    reg_address_in = addr;
    data_in = d;
    cyc(1);
    reg_address_in = A_IDLE;
    data_in = '0;
  endtask

  // One in-window pixel, then let the pipeline drain into the flags.
  task automatic pix(input logic [8:1] bpl, input logic [7:0] spr);
    bpldata = bpl;
    nsprite = spr;
    window  = 1'b1;
    cyc(1);
    window  = 1'b0;
    nsprite = '0;
    bpldata = '0;
    cyc(2);
  endtask

  // Monitor: checks data_out mid-cycle whenever the stimulus presents a read.
  initial begin : monitor
    logic [15:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (done) break;
      if (sample) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_read: data_out=%h with no expected value queued", data_out);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (data_out !== e) begin
            n_bad++;
            $display("FAIL %s: data_out=%h expected %h", nm, data_out, e);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected reads never observed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stimulus
    reset = 1'b1;
    clk7_en = 1'b1;
    aga = 1'b0;
    reg_address_in = A_IDLE;
    data_in = '0;
    bpldata = '0;
    nsprite = '0;
    window = 1'b0;
    cyc(3);
    reset = 1'b0;

    rd(16'h8000, "reset_read");
    expect_out(A_IDLE, 16'h0000, "not_addressed");

    wr(A_CLXCON, 16'h0FFF);
    pix(8'h3F, 8'h00);
    rd(16'h8001, "bp_match");
    pix(8'h3E, 8'h00);
    rd(16'h8000, "bp_mismatch");

    wr(A_CLXCON, 16'h0000);
    pix(8'h00, 8'h05);
    rd(16'h8267, "spr0_spr2");
    rd(16'h8000, "reread_cleared");

    pix(8'h00, 8'h02);
    rd(16'h8001, "ensp1_off");
    wr(A_CLXCON, 16'h1000);
    pix(8'h00, 8'h02);
    rd(16'h8023, "ensp1_on");

    wr(A_CLXCON, 16'h0000);
    pix(8'h00, 8'h41);
    rd(16'h8933, "g0_g3");
    pix(8'h00, 8'h05);
    cyc(3);
    pix(8'h00, 8'h50);
    rd(16'hC3FF, "sticky_or");

    wr(A_CLXCON, 16'h0082);
    pix(8'h00, 8'h01);
    rd(16'h8002, "odd_only");

    wr(A_CLXCON, 16'h0000);
    nsprite = 8'hFF;
    window = 1'b0;
    cyc(100);
    nsprite = '0;
    rd(16'h8000, "window_off");

    aga = 1'b0;
    wr(A_CLXCON2, 16'h0080);
    pix(8'h80, 8'h00);
    rd(16'h8001, "clxcon2_no_aga");
    aga = 1'b1;
    wr(A_CLXCON2, 16'h0080);
    pix(8'h80, 8'h00);
    rd(16'h8000, "clxcon2_enbp8");
    wr(A_CLXCON2, 16'h0040);
    pix(8'h40, 8'h01);
    rd(16'h8020, "clxcon2_enbp7");
    wr(A_CLXCON, 16'h0000);
    pix(8'h80, 8'h00);
    rd(16'h8001, "clxcon_clears_clxcon2");

    // Control write and pixel in the same cycle: old control applies.
    wr(A_CLXCON, 16'h0FFF);
    reg_address_in = A_CLXCON;
    data_in = 16'h0000;
    bpldata = 8'h00;
    window = 1'b1;
    cyc(1);
    reg_address_in = A_IDLE;
    window = 1'b0;
    cyc(2);
    rd(16'h8000, "cfg_next_cycle");
    pix(8'h00, 8'h00);
    rd(16'h8001, "cfg_applied");

    // Clock enable low freezes everything, including clear-on-read.
    pix(8'h00, 8'h00);
    clk7_en = 1'b0;
    rd(16'h8001, "en_low_read");
    window = 1'b1;
    nsprite = 8'h05;
    cyc(3);
    window = 1'b0;
    nsprite = '0;
    clk7_en = 1'b1;
    cyc(2);
    rd(16'h8001, "en_low_hold");
    rd(16'h8000, "en_cleared");

    // Hit in flight during a read is held for the next read.
    window = 1'b1;
    cyc(1);
    window = 1'b0;
    rd(16'h8000, "same_cycle_read");
    rd(16'h8001, "next_read");

    // Reset wins over a simultaneous write and pixel.
    pix(8'h00, 8'h00);
    reset = 1'b1;
    reg_address_in = A_CLXCON;
    data_in = 16'h0FFF;
    window = 1'b1;
    cyc(1);
    reset = 1'b0;
    reg_address_in = A_IDLE;
    data_in = '0;
    window = 1'b0;
    cyc(1);
    rd(16'h8000, "reset_prio");
    pix(8'h00, 8'h00);
    rd(16'h8001, "reset_cfg_cleared");

    cyc(2);
    done = 1'b1;
  end

endmodule
